// File: rtl/fractal_sync_pkg.sv
// Shared configuration, operation/response types and barrier-id mapping helpers
// for the fractal sync read-modify-write front-end.
package fractal_sync_pkg;

    localparam int unsigned CFG_N_PORTS = 4;
    localparam int unsigned CFG_N_BANKS = 2;
    localparam int unsigned CFG_N_WORDS = 16;
    localparam int unsigned CFG_DATA_W  = 8;
    localparam int unsigned CFG_BYTE_W  = 8;

    function automatic int unsigned id_width(input int unsigned n_banks,
                                             input int unsigned n_words);
        return $clog2(n_banks * n_words);
    endfunction

    // Select fields keep at least one bit even when there is nothing to select.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CFG_ID_W     = id_width(CFG_N_BANKS, CFG_N_WORDS);
    localparam int unsigned CFG_PORT_W   = sel_width(CFG_N_PORTS);
    localparam int unsigned CFG_BANK_LOG = $clog2(CFG_N_BANKS);
    localparam int unsigned CFG_BANK_W   = sel_width(CFG_N_BANKS);
    localparam int unsigned CFG_ADDR_W   = $clog2(CFG_N_WORDS);

    typedef logic [CFG_ID_W-1:0] id_t;

    typedef struct packed {
        logic [CFG_PORT_W-1:0] port;
        id_t                   id;
        logic [CFG_DATA_W-1:0] cnt;
    } rmw_op_t;

    typedef struct packed {
        logic                  valid;
        logic [CFG_PORT_W-1:0] port;
        id_t                   id;
        logic                  done;
    } rsp_t;

    // Low id bits pick the bank so consecutive barriers interleave across banks.
    function automatic logic [CFG_BANK_W-1:0] id_bank(input id_t id);
        return CFG_BANK_W'(id % CFG_ID_W'(CFG_N_BANKS));
    endfunction

    function automatic logic [CFG_ADDR_W-1:0] id_addr(input id_t id);
        return CFG_ADDR_W'(id >> CFG_BANK_LOG);
    endfunction

endpackage

// File: rtl/fractal_sync_rr_arb.sv
// Round-robin arbiter: grants the lowest-index request at or after the pointer,
// then moves the pointer just past the winner.
module fractal_sync_rr_arb
    import fractal_sync_pkg::*;
#(
    parameter int unsigned N_PORTS = CFG_N_PORTS
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic [N_PORTS-1:0]             req_i,
    output logic [N_PORTS-1:0]             gnt_o,
    output logic [sel_width(N_PORTS)-1:0]  gnt_idx_o,
    output logic                           gnt_valid_o
);

    localparam int unsigned PORT_W = sel_width(N_PORTS);

    logic [PORT_W-1:0] ptr_q, ptr_d;
    logic [PORT_W-1:0] cand;

    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        cand        = '0;
        for (int unsigned off = 0; off < N_PORTS; off++) begin
            cand = PORT_W'((32'(ptr_q) + off) % N_PORTS);
            if (en_i && !gnt_valid_o && req_i[cand]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid_o) begin
            ptr_d = (gnt_idx_o == PORT_W'(N_PORTS - 1)) ? '0 : gnt_idx_o + PORT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fractal_sync_rmw.sv
// Barrier-arrive read-modify-write front-end for the fractal_rf counter file:
// S0 arbitrates and reads the counter, S1 increments, compares and writes back.
module fractal_sync_rmw
    import fractal_sync_pkg::*;
#(
    parameter int unsigned N_PORTS = CFG_N_PORTS,
    parameter int unsigned N_BANKS = CFG_N_BANKS,
    parameter int unsigned N_WORDS = CFG_N_WORDS,
    parameter int unsigned DATA_W  = CFG_DATA_W,
    parameter int unsigned BYTE_W  = CFG_BYTE_W
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [N_PORTS-1:0]                    req_valid_i,
    output logic [N_PORTS-1:0]                    req_ready_o,
    input  logic [N_PORTS*id_width(N_BANKS, N_WORDS)-1:0] req_id_i,
    input  logic [N_PORTS*DATA_W-1:0]             req_cnt_i,
    output logic                                  rf_req_o,
    output logic                                  rf_we_o,
    output logic [sel_width(N_BANKS)-1:0]         rf_bank_o,
    output logic [$clog2(N_WORDS)-1:0]            rf_addr_o,
    output logic [DATA_W-1:0]                     rf_wdata_o,
    output logic [DATA_W/BYTE_W-1:0]              rf_be_o,
    input  logic [DATA_W-1:0]                     rf_rdata_i,
    output logic                                  rsp_valid_o,
    output logic [sel_width(N_PORTS)-1:0]         rsp_port_o,
    output logic [id_width(N_BANKS, N_WORDS)-1:0] rsp_id_o,
    output logic                                  rsp_done_o
);

    // Internal op/response structs are sized from the package configuration,
    // so instance parameters are expected to match it.
    localparam int unsigned ID_W   = id_width(N_BANKS, N_WORDS);
    localparam int unsigned PORT_W = sel_width(N_PORTS);

    logic [N_PORTS-1:0] gnt;
    logic [PORT_W-1:0]  gnt_idx;
    logic               gnt_valid;
    logic               arb_en;
    logic [ID_W-1:0]    gnt_id;
    logic [DATA_W-1:0]  gnt_cnt;

    rmw_op_t           s1_q, s1_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_fwd_q, s1_fwd_d;
    logic [DATA_W-1:0] s1_fwd_data_q, s1_fwd_data_d;

    logic              fwd_valid_q, fwd_valid_d;
    logic [ID_W-1:0]   fwd_id_q, fwd_id_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

    logic              s1_fire;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] sum;
    logic              s1_done;
    logic [DATA_W-1:0] s1_wdata;
    rsp_t              rsp;

    // S1 owns the RF port, so S0 may only issue when S1 is empty.
    assign arb_en = !s1_valid_q && !rst_i;

    fractal_sync_rr_arb #(
        .N_PORTS (N_PORTS)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (arb_en),
        .req_i       (req_valid_i),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign gnt_id  = req_id_i[int'(gnt_idx)*ID_W +: ID_W];
    assign gnt_cnt = req_cnt_i[int'(gnt_idx)*DATA_W +: DATA_W];

    assign s1_fire  = s1_valid_q && !rst_i;
    assign cur      = s1_fwd_q ? s1_fwd_data_q : rf_rdata_i;
    assign sum      = cur + DATA_W'(1);
    assign s1_done  = (sum == s1_q.cnt);
    assign s1_wdata = s1_done ? '0 : sum;

    always_comb begin
        s1_valid_d    = gnt_valid;
        s1_d          = s1_q;
        s1_fwd_d      = 1'b0;
        s1_fwd_data_d = s1_fwd_data_q;
        if (gnt_valid) begin
            s1_d.port = gnt_idx;
            s1_d.id   = gnt_id;
            s1_d.cnt  = gnt_cnt;
            // The RF may still return the pre-write value for a read issued right
            // after a write, so capture the bypass decision alongside the op.
            s1_fwd_d      = fwd_valid_q && (fwd_id_q == gnt_id);
            s1_fwd_data_d = fwd_data_q;
        end
    end

    always_comb begin
        fwd_valid_d = s1_fire;
        fwd_id_d    = fwd_id_q;
        fwd_data_d  = fwd_data_q;
        if (s1_fire) begin
            fwd_id_d   = s1_q.id;
            fwd_data_d = s1_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q    <= 1'b0;
            s1_q          <= '0;
            s1_fwd_q      <= 1'b0;
            s1_fwd_data_q <= '0;
            fwd_valid_q   <= 1'b0;
            fwd_id_q      <= '0;
            fwd_data_q    <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_q          <= s1_d;
            s1_fwd_q      <= s1_fwd_d;
            s1_fwd_data_q <= s1_fwd_data_d;
            fwd_valid_q   <= fwd_valid_d;
            fwd_id_q      <= fwd_id_d;
            fwd_data_q    <= fwd_data_d;
        end
    end

    always_comb begin
        rsp       = '0;
        rsp.valid = s1_fire;
        if (s1_fire) begin
            rsp.port = s1_q.port;
            rsp.id   = s1_q.id;
            rsp.done = s1_done;
        end
    end

    always_comb begin
        req_ready_o = gnt;
        rf_req_o    = 1'b0;
        rf_we_o     = 1'b0;
        rf_bank_o   = '0;
        rf_addr_o   = '0;
        rf_wdata_o  = '0;
        rf_be_o     = '0;
        if (s1_fire) begin
            rf_req_o   = 1'b1;
            rf_we_o    = 1'b1;
            rf_bank_o  = id_bank(s1_q.id);
            rf_addr_o  = id_addr(s1_q.id);
            rf_wdata_o = s1_wdata;
            rf_be_o    = '1;
        end else if (gnt_valid) begin
            rf_req_o  = 1'b1;
            rf_bank_o = id_bank(gnt_id);
            rf_addr_o = id_addr(gnt_id);
        end
        rsp_valid_o = rsp.valid;
        rsp_port_o  = rsp.port;
        rsp_id_o    = rsp.id;
        rsp_done_o  = rsp.done;
    end

    // A zero participant count can never complete; treat it as a protocol error.
    always_ff @(posedge clk_i) begin
        if (!rst_i && gnt_valid) begin
            assert (gnt_cnt != '0)
            else $error("fractal_sync_rmw: zero participant count on port %0d", gnt_idx);
        end
    end

endmodule
